// File: rtl/f_pc_unit.sv
// Fetch-stage program counter: next-PC select, a one-entry redirect buffer that
// holds a redirect raised while fetch is stalled, and a fetch-address fault flag.
module f_pc_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_PC   = 32'h0000_4180,
  parameter logic [WIDTH-1:0] PC_MIN   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] PC_MAX   = 32'h0000_6ffc
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       mpc_c,
  input  logic [WIDTH-1:0] npc,
  input  logic [WIDTH-1:0] rfrd1,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4,
  output logic             pend_valid,
  output logic             fetch_exc
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic             pend_valid_q, pend_valid_d;
  logic             redirect;
  logic [WIDTH-1:0] target;

  always_comb begin
    redirect = 1'b0;
    target   = npc;
    case (mpc_c)
      2'd1: begin
        redirect = 1'b1;
        target   = npc;
      end
      2'd2: begin
        redirect = 1'b1;
        target   = rfrd1;
      end
      default: begin
        redirect = 1'b0;
        target   = npc;
      end
    endcase
  end

  assign pc4 = pc_q + {{(WIDTH-3){1'b0}}, 3'd4};

  // Exception and eret beat everything, including a stall and a pending redirect.
  always_comb begin
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    if (exc_req) begin
      pc_d         = EXC_PC;
      pend_valid_d = 1'b0;
    end else if (eret_req) begin
      pc_d         = epc;
      pend_valid_d = 1'b0;
    end else if (stall) begin
      if (redirect) begin
        pend_addr_d  = target;
        pend_valid_d = 1'b1;
      end
    end else if (redirect) begin
      pc_d         = target;
      pend_valid_d = 1'b0;
    end else if (pend_valid_q) begin
      pc_d         = pend_addr_q;
      pend_valid_d = 1'b0;
    end else begin
      pc_d = pc4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign pc         = pc_q;
  assign pend_valid = pend_valid_q;
  assign fetch_exc  = (pc_q[1:0] != 2'b00) || (pc_q < PC_MIN) || (pc_q > PC_MAX);

endmodule

// File: tb/tb_f_pc_unit.sv
// Self-checking bench for f_pc_unit: directed vector table, async reset sequence,
// then randomized traffic against a priority-rule reference model.
module tb_f_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  mpc_c;
  logic [31:0] npc, rfrd1, epc;
  logic        exc_req, eret_req;
  logic [31:0] pc, pc4;
  logic        pend_valid, fetch_exc;

  int tests_run = 0;
  int tests_failed = 0;

  f_pc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .mpc_c      (mpc_c),
    .npc        (npc),
    .rfrd1      (rfrd1),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .pc         (pc),
    .pc4        (pc4),
    .pend_valid (pend_valid),
    .fetch_exc  (fetch_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [1:0]  mpc_c;
    logic [31:0] npc;
    logic [31:0] rfrd1;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] exp_pc;
    logic        exp_pv;
    logic        exp_fx;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_fx(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6ffc);
  endfunction

  task automatic add(input logic s, input logic [1:0] m, input logic [31:0] n,
                     input logic [31:0] r, input logic e, input logic er,
                     input logic [31:0] ep, input logic [31:0] xpc, input logic xpv);
    vec_t v;
    v.stall = s; v.mpc_c = m; v.npc = n; v.rfrd1 = r; v.exc = e; v.eret = er;
    v.epc = ep; v.exp_pc = xpc; v.exp_pv = xpv; v.exp_fx = ref_fx(xpc);
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    stall = 0; mpc_c = 0; npc = 0; rfrd1 = 0; exc_req = 0; eret_req = 0; epc = 0;
  endtask

  // Reference model state
  logic [31:0] m_pc, m_pa;
  logic        m_pv;

  task automatic model_edge();
    logic        redir;
    logic [31:0] tgt;
    redir = (mpc_c == 2'd1) || (mpc_c == 2'd2);
    tgt   = (mpc_c == 2'd1) ? npc : rfrd1;
    if (exc_req) begin
      m_pc = 32'h4180; m_pv = 0;
    end else if (eret_req) begin
      m_pc = epc; m_pv = 0;
    end else if (stall) begin
      if (redir) begin m_pa = tgt; m_pv = 1; end
    end else if (redir) begin
      m_pc = tgt; m_pv = 0;
    end else if (m_pv) begin
      m_pc = m_pa; m_pv = 0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return $urandom();
    return 32'h3000 + ($urandom_range(0, 32'hfff) << 2);
  endfunction

  initial begin
    reset = 1'b1;
    drive_idle();
    #3;
    check("reset_pc", pc, 32'h3000);
    check("reset_pc4", pc4, 32'h3004);
    check("reset_pv", {31'b0, pend_valid}, 32'd0);
    check("reset_fx", {31'b0, fetch_exc}, 32'd0);
    #9 reset = 1'b0;  // released between edges

    add(0, 0, 0, 0, 0, 0, 0, 32'h3004, 0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h3008, 0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h300c, 0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h3010, 0);
    add(0, 1, 32'h3400, 0, 0, 0, 0, 32'h3400, 0);
    add(0, 2, 32'h9999, 32'h3800, 0, 0, 0, 32'h3800, 0);
    add(0, 1, 32'h3020, 0, 0, 0, 0, 32'h3020, 0);
    add(1, 1, 32'h3500, 0, 0, 0, 0, 32'h3020, 1);
    add(1, 0, 0, 0, 0, 0, 0, 32'h3020, 1);
    add(1, 0, 0, 0, 0, 0, 0, 32'h3020, 1);
    add(0, 0, 0, 0, 0, 0, 0, 32'h3500, 0);
    add(1, 1, 32'h3500, 0, 0, 0, 0, 32'h3500, 1);
    add(1, 1, 32'h3600, 0, 0, 0, 0, 32'h3500, 1);
    add(0, 2, 0, 32'h3700, 0, 0, 0, 32'h3700, 0);
    add(1, 1, 32'h3500, 0, 0, 0, 0, 32'h3700, 1);
    add(1, 2, 0, 32'h3600, 0, 0, 0, 32'h3700, 1);
    add(0, 0, 0, 0, 0, 0, 0, 32'h3600, 0);
    add(1, 1, 32'h3900, 0, 0, 0, 0, 32'h3600, 1);
    add(1, 1, 32'h3a00, 0, 1, 1, 32'h3044, 32'h4180, 0);
    add(0, 0, 0, 0, 0, 1, 32'h3044, 32'h3044, 0);
    add(1, 3, 32'h5000, 32'h5000, 0, 0, 0, 32'h3044, 0);
    add(0, 3, 32'h5000, 32'h5000, 0, 0, 0, 32'h3048, 0);
    add(0, 1, 32'h3002, 0, 0, 0, 0, 32'h3002, 0);
    add(0, 1, 32'h7000, 0, 0, 0, 0, 32'h7000, 0);
    add(0, 1, 32'h6ffc, 0, 0, 0, 0, 32'h6ffc, 0);
    add(0, 1, 32'h2ffc, 0, 0, 0, 0, 32'h2ffc, 0);
    add(0, 1, 32'hffff_fffc, 0, 0, 0, 0, 32'hffff_fffc, 0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0000_0004, 0);

    foreach (vecs[i]) begin
      stall = vecs[i].stall; mpc_c = vecs[i].mpc_c; npc = vecs[i].npc;
      rfrd1 = vecs[i].rfrd1; exc_req = vecs[i].exc; eret_req = vecs[i].eret;
      epc = vecs[i].epc;
      @(posedge clk); #1;
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_pc4", i), pc4, vecs[i].exp_pc + 32'd4);
      check($sformatf("vec%0d_pv", i), {31'b0, pend_valid}, {31'b0, vecs[i].exp_pv});
      check($sformatf("vec%0d_fx", i), {31'b0, fetch_exc}, {31'b0, vecs[i].exp_fx});
    end

    // Async reset mid-operation discards a pending redirect
    drive_idle();
    stall = 1; mpc_c = 1; npc = 32'h3abc;
    @(posedge clk); #1;
    check("pre_rst_pv", {31'b0, pend_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_pc", pc, 32'h3000);
    check("mid_rst_pc4", pc4, 32'h3004);
    check("mid_rst_pv", {31'b0, pend_valid}, 32'd0);
    drive_idle();
    #2 reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_pc%0d", k), pc, 32'h3000 + 32'(4 * k));
      check($sformatf("post_rst_pv%0d", k), {31'b0, pend_valid}, 32'd0);
    end

    // Randomized traffic against the reference model
    m_pc = 32'h300c; m_pv = 0; m_pa = 0;
    for (int n = 0; n < 500; n++) begin
      stall    = ($urandom_range(0, 2) == 0);
      mpc_c    = 2'($urandom_range(0, 3));
      npc      = rand_addr();
      rfrd1    = rand_addr();
      epc      = rand_addr();
      exc_req  = ($urandom_range(0, 19) == 0);
      eret_req = ($urandom_range(0, 19) == 0);
      model_edge();
      @(posedge clk); #1;
      check($sformatf("rnd%0d_pc", n), pc, m_pc);
      check($sformatf("rnd%0d_pv", n), {31'b0, pend_valid}, {31'b0, m_pv});
      check($sformatf("rnd%0d_pc4", n), pc4, m_pc + 32'd4);
      check($sformatf("rnd%0d_fx", n), {31'b0, fetch_exc}, {31'b0, ref_fx(m_pc)});
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
